// File: rtl/spi_master_multi.sv
// Parametrised SPI master: one shared SCLK/MOSI pair, one active-low chip
// select and one MISO input per slave, mode (CPOL/CPHA) chosen per transfer.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   start              transfer request (sampled only while idle)
//   slave_sel          target slave index
//   cpol, cpha         SPI mode for the requested transfer
//   tx_data            word to send
//   miso               per-slave serial input
//   sclk, mosi         serial clock / serial output
//   cs_n               active-low selects, one-hot-low while active
//   busy               high from accept through trailing hold
//   done               one-cycle pulse, rx_data valid
//   err                one-cycle pulse, start rejected (slave_sel out of range)
//   rx_data            last received word
module spi_master_multi #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned N_SLAVES  = 3,
    parameter int unsigned CLKDIV    = 2,
    parameter int unsigned LSB_FIRST = 0,
    localparam int unsigned SEL_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [SEL_W-1:0]    slave_sel,
    input  logic                cpol,
    input  logic                cpha,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic [N_SLAVES-1:0] miso,
    output logic                sclk,
    output logic                mosi,
    output logic [N_SLAVES-1:0] cs_n,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   rx_data
);

    localparam int unsigned DIV_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int unsigned EDGES  = 2 * DATA_W;
    localparam int unsigned EDGE_W = $clog2(EDGES + 1);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLKDIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_XFER,
        S_TRAIL
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic [N_SLAVES-1:0] cs_n_q, cs_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;

    logic                tick;
    logic [EDGE_W-1:0]   next_edge;
    logic                leading;
    logic                last_edge;
    logic                miso_bit;
    logic                sel_valid;

    // Bit presented first on the wire for a given shift-register value.
    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        return (LSB_FIRST != 0) ? v[0] : v[DATA_W-1];
    endfunction

    // Drop the bit just sent.
    function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] v);
        return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
    endfunction

    // Insert a sampled bit so the first bit received ends at the first-bit position.
    function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] v,
                                                    input logic b);
        return (LSB_FIRST != 0) ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
    endfunction

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        edge_d    = edge_q;
        sel_d     = sel_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rx_data_d = rx_data_q;

        tick      = (div_q == '0);
        next_edge = edge_q + EDGE_W'(1);
        leading   = next_edge[0];
        last_edge = (next_edge == EDGE_W'(EDGES));
        miso_bit  = miso[sel_q];
        sel_valid = ({1'b0, slave_sel} < (SEL_W + 1)'(N_SLAVES));

        case (state_q)
            S_IDLE: begin
                sclk_d = cpol;
                if (start) begin
                    if (sel_valid) begin
                        state_d = S_LEAD;
                        div_d   = DIV_RELOAD;
                        edge_d  = '0;
                        sel_d   = slave_sel;
                        cpol_d  = cpol;
                        cpha_d  = cpha;
                        rx_d    = '0;
                        cs_n_d  = ~(N_SLAVES'(1) << slave_sel);
                        busy_d  = 1'b1;
                        // CPHA=0 puts the first bit out before the first edge.
                        if (!cpha) begin
                            mosi_d = first_bit(tx_data);
                            tx_d   = shift_tx(tx_data);
                        end else begin
                            mosi_d = 1'b0;
                            tx_d   = tx_data;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_LEAD, S_XFER: begin
                if (!tick) begin
                    div_d = div_q - DIV_W'(1);
                end else begin
                    div_d  = DIV_RELOAD;
                    edge_d = next_edge;
                    sclk_d = ~sclk_q;
                    if (state_q == S_LEAD) begin
                        state_d = S_XFER;
                    end
                    // Sample on leading edges for CPHA=0, trailing for CPHA=1;
                    // the other edge type shifts the next bit out.
                    if (leading != cpha_q) begin
                        rx_d = shift_rx(rx_q, miso_bit);
                    end else begin
                        mosi_d = first_bit(tx_q);
                        tx_d   = shift_tx(tx_q);
                    end
                    if (last_edge) begin
                        mosi_d  = 1'b0;
                        sclk_d  = cpol_q;
                        state_d = S_TRAIL;
                    end
                end
            end

            S_TRAIL: begin
                if (!tick) begin
                    div_d = div_q - DIV_W'(1);
                end else begin
                    state_d   = S_IDLE;
                    cs_n_d    = '1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_q;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            edge_q    <= '0;
            sel_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            sel_q     <= sel_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rx_data = rx_data_q;

endmodule

// File: doc/spi_master_multi.md
# spi_master_multi

Parametrised SPI master. It drives one shared SCLK/MOSI pair and one active-low chip select per slave, with a per-slave MISO mux. Word width, slave count, SCLK divider and bit order are configurable; SPI mode (CPOL/CPHA) is chosen per transfer. A host starts each transfer with a start/busy/done handshake. The block replaces the fixed 16-bit, three-slave, level-selected master in the SPI subsystem.

## Interface
Parameters:
- DATA_W, 16, bits per transfer (≥2)
- N_SLAVES, 3, number of chip selects / MISO inputs (≥1)
- CLKDIV, 2, clk cycles per SCLK half-period (≥1)
- LSB_FIRST, 0, 0 = MSB first, 1 = LSB first (applies to both tx and rx)
- SEL_W, derived: $clog2(N_SLAVES), minimum 1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  transfer request, sampled only in IDLE
- slave_sel  in  SEL_W  target slave index
- cpol  in  1  SCLK idle level
- cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge
- tx_data  in  DATA_W  word to send
- miso  in  N_SLAVES  per-slave serial input
- sclk  out  1  serial clock
- mosi  out  1  serial output
- cs_n  out  N_SLAVES  active-low selects, one-hot-low when active
- busy  out  1  high from accept through TRAIL
- done  out  1  one-cycle pulse, rx_data valid
- err  out  1  one-cycle pulse, start rejected because slave_sel ≥ N_SLAVES
- rx_data  out  DATA_W  last received word, held until next done

## Operation
- Reset values: sclk=0, mosi=0, cs_n=all 1, busy=0, done=0, err=0, rx_data=0, state IDLE.
- Reset asserted mid-transfer forces all outputs to their reset values immediately. No done pulse.
- States: IDLE → LEAD → XFER → TRAIL → IDLE.
- IDLE:
  - sclk registers the cpol input every cycle.
  - start=1 with slave_sel<N_SLAVES: latch tx_data, slave_sel, cpol and cpha; go to LEAD.
  - start=1 with slave_sel≥N_SLAVES: err=1 for one cycle; stay in IDLE.
- LEAD: cs_n[sel]=0 and busy=1. Lasts CLKDIV cycles; this is the setup time. On exit, the first SCLK edge is issued and the state becomes XFER.
- XFER: SCLK toggles every CLKDIV cycles, 2·DATA_W edges in total. Odd edges are leading; even edges are trailing. After the final trailing edge, sclk equals the latched cpol.
- CPHA=0:
  - mosi holds the first bit from LEAD entry.
  - Sample on leading edges; update mosi to the next bit on trailing edges.
  - After the final trailing edge, mosi=0.
- CPHA=1:
  - mosi=0 in LEAD.
  - Update mosi to the next bit on leading edges; sample on trailing edges.
  - mosi=0 after the final trailing edge.
- Sampling: at the clk edge that toggles sclk, capture miso[latched sel] into the rx shift register. MSB-first shifts left; LSB-first shifts right.
- TRAIL: CLKDIV cycles with cs_n still asserted and sclk idle. On exit:
  - state IDLE, cs_n all 1, busy=0
  - done=1 for one cycle; rx_data loads the shift register in the same cycle.
- start while busy is ignored. Changes to cpol, cpha, tx_data or slave_sel during a transfer have no effect.
- All outputs are registered; there is no combinational path from input to output.

## Timing
- Let E0 be the clk edge that accepts start.
  - From E0: busy=1, cs_n[sel]=0.
  - SCLK edge k (1…2·DATA_W) occurs at E0 + k·CLKDIV.
  - TRAIL exit, done and busy=0 occur at E0 + (2·DATA_W+1)·CLKDIV.
- Defaults (DATA_W=16, CLKDIV=2): done 66 cycles after E0.
- SCLK period = 2·CLKDIV clk cycles.
- Back-to-back: a start in the cycle after done is accepted. Minimum cs_n high time is 1 cycle.
- err pulses in the cycle after the rejected start. busy stays 0.

## Test plan
- Mode 0, default parameters, slave 1, tx_data=16'hA5C3, miso[1] looped from mosi → rx_data=16'hA5C3; done at E0+66; cs_n=3'b101 during transfer; exactly 32 sclk edges; sclk idle 0.
- Mode 3, slave 2, slave model shifting 16'h1234 out on the leading edge → rx_data=16'h1234; sclk idle 1 before and after; mosi carries tx_data=16'hFFFF; only cs_n[2] low.
- Modes 1 and 2 with LSB_FIRST=1, tx_data=16'h0001, loopback → rx_data=16'h0001; first mosi bit observed is 1.
- slave_sel=3 with N_SLAVES=3 → err pulse of 1 cycle; cs_n stays 3'b111; busy stays 0. Then a start during an active transfer is ignored: a single done, rx_data from the first word.
- rst_n low at E0+20 → sclk=0, mosi=0, cs_n=3'b111, busy=0 immediately; no done. A subsequent transfer with CLKDIV=1 completes at E0+33.
